// File: rtl/axis_fifo_rr_arb.sv
// Round-robin arbiter that merges NUM_SRC AXI-Stream producers onto one FIFO write port.
// A grant lasts for a whole packet or MAX_BEATS beats, and every forwarded beat is tagged with the source index.
module axis_fifo_rr_arb #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_WDTH = 8,
    parameter int MAX_BEATS = 16,
    localparam int IDW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int BCW      = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC*DATA_WDTH-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]             s_axis_tvalid,
    input  logic [NUM_SRC-1:0]             s_axis_tlast,
    output logic [NUM_SRC-1:0]             s_axis_tready,
    output logic [DATA_WDTH-1:0]           m_axis_tdata,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    output logic [IDW-1:0]                 m_axis_tid,
    input  logic                           m_axis_tready,
    output logic                           arb_busy
);

    localparam logic [0:0] ARB   = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam int LAST_BEAT     = (MAX_BEATS > 0) ? MAX_BEATS - 1 : 0;

    if (!(DATA_WDTH == 8 || DATA_WDTH == 16 || DATA_WDTH == 32 || DATA_WDTH == 64)) begin : g_bad_wdth
        $fatal(1, "axis_fifo_rr_arb: DATA_WDTH must be 8, 16, 32 or 64");
    end

    logic [0:0]           state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;

    logic [2*NUM_SRC-1:0] rotValid;
    logic [IDW:0]         pickOffset;
    logic [IDW:0]         pickSum;
    logic [IDW-1:0]       pick;
    logic                 pickValid;

    logic [DATA_WDTH-1:0] selData;
    logic                 selValid;
    logic                 selLast;
    logic                 busy;
    logic                 accept;
    logic                 atLimit;
    logic [IDW-1:0]       nextPtr;

    // Rotate the request vector so that bit 0 is the source at rr_ptr; the lowest set bit wins.
    always_comb begin
        rotValid   = {s_axis_tvalid, s_axis_tvalid} >> rr_ptr_q;
        pickOffset = '0;
        pickValid  = 1'b0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rotValid[k]) begin
                pickOffset = (IDW+1)'(k);
                pickValid  = 1'b1;
            end
        end
        pickSum = {1'b0, rr_ptr_q} + pickOffset;
        if (pickSum >= (IDW+1)'(NUM_SRC)) begin
            pickSum = pickSum - (IDW+1)'(NUM_SRC);
        end
        pick = pickSum[IDW-1:0];
    end

    always_comb begin
        selData  = '0;
        selValid = 1'b0;
        selLast  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == IDW'(i)) begin
                selData  = s_axis_tdata[i*DATA_WDTH +: DATA_WDTH];
                selValid = s_axis_tvalid[i];
                selLast  = s_axis_tlast[i];
            end
        end
    end

    // Forwarding is purely combinational while a grant is held; everything is quiet in ARB.
    always_comb begin
        busy          = (state_q == GRANT);
        m_axis_tvalid = busy & selValid;
        m_axis_tlast  = busy & selLast;
        m_axis_tdata  = busy ? selData : '0;
        m_axis_tid    = busy ? grant_q : '0;
        arb_busy      = busy;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_axis_tready[i] = busy & m_axis_tready & (grant_q == IDW'(i));
        end
    end

    always_comb begin
        accept  = m_axis_tvalid & m_axis_tready;
        atLimit = (MAX_BEATS != 0) && (beat_cnt_q == BCW'(LAST_BEAT));
        nextPtr = (grant_q == IDW'(NUM_SRC - 1)) ? '0 : grant_q + IDW'(1);
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB: begin
                if (pickValid) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                    // A beat that is both tlast and the beat limit still releases only once.
                    if (selLast || atLimit) begin
                        state_d  = ARB;
                        rr_ptr_d = nextPtr;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
